// File: rtl/trace_axis_downsizer.sv
// Wide-to-narrow trace AXI-Stream downsizer: one IN_WIDTH packet -> BEATS OUT_WIDTH beats, LSW first.
// Optional TRACE_DOWNSIZER_TIMESTAMP_EN appends a cycle-count beat captured at packet acceptance.
module trace_axis_downsizer #(
  parameter int IN_WIDTH  = 96,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [31:0]          pkt_count
);
  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
`ifdef TRACE_DOWNSIZER_TIMESTAMP_EN
  localparam int NBEATS = BEATS + 1;
`else
  localparam int NBEATS = BEATS;
`endif
  localparam int IDXW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;

  logic [IN_WIDTH-1:0]  hold_data;
  logic                 hold_last;
  logic [IDXW-1:0]      beat_idx, nxt_idx;
  logic [OUT_WIDTH-1:0] nxt_word;
  logic                 nxt_last, last_beat, pkt_done, accept, beat_fire;

`ifdef TRACE_DOWNSIZER_TIMESTAMP_EN
  logic [OUT_WIDTH-1:0] ts_cnt, ts_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  assign last_beat = (beat_idx == IDXW'(NBEATS - 1));
  assign beat_fire = m_axis_tvalid & m_axis_tready;
  assign pkt_done  = beat_fire & last_beat;
  // Reopening on the final handshake lets the next packet follow with no bubble.
  assign s_axis_tready = rst_n & ((state_q == IDLE) | pkt_done);
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (pkt_done) state_d = accept ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nxt_idx  = beat_idx + 1'b1;
    nxt_word = '0;
    if (int'(nxt_idx) < BEATS)
      nxt_word = hold_data[OUT_WIDTH*int'(nxt_idx) +: OUT_WIDTH];
`ifdef TRACE_DOWNSIZER_TIMESTAMP_EN
    else
      nxt_word = ts_hold;
`endif
    nxt_last = hold_last & (nxt_idx == IDXW'(NBEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_data     <= '0;
      hold_last     <= 1'b0;
      beat_idx      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_count     <= '0;
`ifdef TRACE_DOWNSIZER_TIMESTAMP_EN
      ts_hold       <= '0;
`endif
    end else begin
      m_axis_tvalid <= (state_d == SEND);
      if (pkt_done) pkt_count <= pkt_count + 32'd1;
      if (accept) begin
        // Word 0 comes straight from the input so it is visible one cycle after capture.
        hold_data    <= s_axis_tdata;
        hold_last    <= s_axis_tlast;
        beat_idx     <= '0;
        m_axis_tdata <= s_axis_tdata[OUT_WIDTH-1:0];
        m_axis_tlast <= s_axis_tlast & (NBEATS == 1);
`ifdef TRACE_DOWNSIZER_TIMESTAMP_EN
        ts_hold      <= ts_cnt;
`endif
      end else if (beat_fire & ~last_beat) begin
        beat_idx     <= nxt_idx;
        m_axis_tdata <= nxt_word;
        m_axis_tlast <= nxt_last;
      end else if (pkt_done) begin
        beat_idx     <= '0;
        m_axis_tlast <= 1'b0;
      end
    end
  end
endmodule

// File: doc/trace_axis_downsizer.md
Name: trace_axis_downsizer

Overview:
- Consumes the wide trace AXI-Stream from the monitoring stage: each beat is one packet of {pc[63:0], instr[31:0]}, 96 bits.
- Re-emits each packet as several narrow beats so it can feed a 32-bit DMA/stream port.
- Preserves packet boundaries and tlast.
- Keeps a running count of emitted packets.

Parameters:
- IN_WIDTH, 96, input packet width in bits.
- OUT_WIDTH, 32, output beat width in bits. IN_WIDTH must be an integer multiple of OUT_WIDTH.
- BEATS, IN_WIDTH/OUT_WIDTH (derived localparam, 3 by default), number of data beats per packet.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- s_axis_tvalid  input  1  upstream packet valid
- s_axis_tready  output  1  downsizer can accept a packet
- s_axis_tdata  input  IN_WIDTH  packet {pc, instr}
- s_axis_tlast  input  1  packet closes a transfer
- m_axis_tvalid  output  1  output beat valid
- m_axis_tready  input  1  downstream accepts beat
- m_axis_tdata  output  OUT_WIDTH  output beat
- m_axis_tlast  output  1  final beat of a tlast packet
- pkt_count  output  32  number of packets whose final beat has been accepted; wraps at 2^32

Behaviour:
- Reset is synchronous, active-low (rst_n) on clk. When rst_n=0 at a clk edge:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, pkt_count=0.
  - Holding register cleared, beat_idx=0, state=IDLE.
  - s_axis_tready is driven 0 while rst_n=0.
- State IDLE (holding register empty):
  - s_axis_tready=1.
  - On s_axis_tvalid&s_axis_tready: capture tdata/tlast into the holding register and go to SEND.
  - m_axis_tvalid rises the next cycle with word 0. Input-to-first-output latency is 1 cycle.
- State SEND:
  - m_axis_tdata = holding[OUT_WIDTH*beat_idx +: OUT_WIDTH]. Least-significant word goes first: instr, pc[31:0], pc[63:32].
  - On m_axis_tvalid&m_axis_tready: beat_idx increments. m_axis_tdata and m_axis_tlast are registered and update on the same edge.
  - m_axis_tlast=1 only on the final beat, and only if the captured tlast was 1.
- Final beat accepted:
  - pkt_count increments.
  - If s_axis_tvalid is also high in that cycle, s_axis_tready=1 combinationally, the next packet is captured, beat_idx returns to 0 and the state stays SEND. There are no bubbles, so sustained throughput is 1 packet per BEATS cycles.
  - Otherwise go to IDLE and m_axis_tvalid falls.
- Rule for s_axis_tready: ~busy | (m_axis_tvalid & m_axis_tready & last_beat). No other path asserts it.
- Backpressure: while m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tvalid are held stable. Once asserted, m_axis_tvalid never drops without a handshake.
- Upstream tvalid without ready: the input is ignored and the holding register is unchanged.
- Reset mid-packet: the partially sent packet is discarded and pkt_count is not incremented. The first post-reset packet starts at word 0.
- pkt_count wraps: 0xFFFFFFFF goes to 0 on the next completed packet.

Optional Feature:
- Macro TRACE_DOWNSIZER_TIMESTAMP_EN.
- When defined:
  - A free-running OUT_WIDTH-bit cycle counter, reset to 0, increments every cycle and wraps.
  - Its value is latched on the edge where the input packet is accepted.
  - The latched value is emitted as one extra beat after the BEATS data beats, giving BEATS+1 beats per packet.
  - m_axis_tlast moves to the timestamp beat.
  - pkt_count increments on acceptance of the timestamp beat.
- When undefined: no counter exists and each packet is exactly BEATS beats.

Test Plan:
1. Single packet, m_axis_tready=1: s_axis_tdata=0x0000000080000010_00000013, tlast=0 -> beats 0x00000013, 0x80000010, 0x00000000 on 3 consecutive cycles starting 1 cycle after acceptance; tlast=0 on all beats; pkt_count=1.
2. Back-to-back packets A,B with tlast on B, tready=1 -> 6 consecutive valid beats with no gap; s_axis_tready pulses high in the cycle of A's 3rd beat; tlast=1 only on beat 6; pkt_count=2.
3. Backpressure: m_axis_tready=0 for 5 cycles on beat 1 -> tdata held 0x80000010, tvalid held 1, s_axis_tready=0 throughout; sequence completes unchanged after tready returns.
4. Reset mid-packet: assert rst_n=0 after beat 0 accepted -> tvalid=0, pkt_count=0 next cycle; next packet starts at its word 0.
5. Wrap: force pkt_count near 0xFFFFFFFF by sending 2^32-1 packets (or via a bench hierarchical deposit) -> after one more packet pkt_count=0.
6. With TRACE_DOWNSIZER_TIMESTAMP_EN defined: packet accepted at cycle count 0x2A, tlast=1 -> 4 beats, 4th=0x0000002A with tlast=1; 3rd beat tlast=0.
